// File: rtl/and_dec_div8b_unit.sv
// Sequenced 8-bit execution unit: AND and DEC complete in one cycle, DIV runs a
// restoring shift-subtract divide (one quotient bit per cycle, MSB first).
module and_dec_div8b_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  output logic [7:0] result,
  output logic [7:0] rest,
  output logic       cout,
  output logic       div_zero,
  output logic       zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_DEC = 2'b01,
    OP_DIV = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic {
    IDLE,
    DIV_RUN
  } state_e;

  state_e     state;
  logic [2:0] iter;
  logic [7:0] quo_q;      // dividend bits shift out the top, quotient bits shift in below
  logic [7:0] divisor_q;
  logic [7:0] prem_q;

  logic [8:0] prem_shift;
  logic [8:0] diff;
  logic       q_bit;
  logic [7:0] prem_next;
  logic [7:0] quo_next;

  // One restoring-division step. prem_shift < 2*divisor, so the 9-bit difference
  // has bit 8 set exactly when the trial subtraction borrows.
  always_comb begin
    prem_shift = {prem_q, quo_q[7]};
    diff       = prem_shift - {1'b0, divisor_q};
    q_bit      = ~diff[8];
    prem_next  = q_bit ? diff[7:0] : prem_shift[7:0];
    quo_next   = {quo_q[6:0], q_bit};
  end

  // NOTE: state and output registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter      <= 3'd0;
      quo_q     <= 8'h00;
      divisor_q <= 8'h00;
      prem_q    <= 8'h00;
      result    <= 8'h00;
      rest      <= 8'h00;
      cout      <= 1'b0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_AND: begin
                result   <= num1 & num2;
                rest     <= 8'h00;
                cout     <= 1'b0;
                div_zero <= 1'b0;
                done     <= 1'b1;
              end
              OP_DEC: begin
                result   <= num1 - 8'd1;
                rest     <= 8'h00;
                cout     <= (num1 == 8'h00);
                div_zero <= 1'b0;
                done     <= 1'b1;
              end
              OP_DIV: begin
                if (num2 == 8'h00) begin
                  result   <= 8'hFF;
                  rest     <= num1;
                  cout     <= 1'b0;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  state     <= DIV_RUN;
                  iter      <= 3'd0;
                  quo_q     <= num1;
                  divisor_q <= num2;
                  prem_q    <= 8'h00;
                end
              end
              OP_RSV: begin
                result   <= 8'h00;
                rest     <= 8'h00;
                cout     <= 1'b0;
                div_zero <= 1'b0;
                done     <= 1'b1;
              end
            endcase
          end
        end
        DIV_RUN: begin
          quo_q  <= quo_next;
          prem_q <= prem_next;
          iter   <= iter + 3'd1;
          if (iter == 3'd7) begin
            state    <= IDLE;
            result   <= quo_next;
            rest     <= prem_next;
            cout     <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state == DIV_RUN);
  assign zero = (result == 8'h00);

endmodule

// File: tb/tb_and_dec_div8b_unit.sv
// Self-checking bench for and_dec_div8b_unit: directed vector table, random ops
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_and_dec_div8b_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [7:0] result;
  logic [7:0] rest;
  logic       cout;
  logic       div_zero;
  logic       zero;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  and_dec_div8b_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .num1     (num1),
    .num2     (num2),
    .result   (result),
    .rest     (rest),
    .cout     (cout),
    .div_zero (div_zero),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] rst;
    logic       cout;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation rules.
  function automatic vec_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int   t;
    v.op = o; v.a = a; v.b = b;
    v.res = 8'h00; v.rst = 8'h00; v.cout = 1'b0; v.dz = 1'b0; v.lat = 0;
    case (o)
      2'd0: v.res = a & b;
      2'd1: begin
        t      = (int'(a) + 255) % 256;
        v.res  = t[7:0];
        v.cout = (a == 8'h00);
      end
      2'd2: begin
        if (b == 8'h00) begin
          v.res = 8'hFF; v.rst = a; v.dz = 1'b1;
        end else begin
          v.res = a / b; v.rst = a % b; v.lat = 8;
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output bit timed_out);
    lat = 0; busy_cnt = 0; timed_out = 1'b0;
    @(negedge clk);
    op = o; num1 = a; num2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat >= 20) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat, busy_cnt;
    bit to;
    run_op(v.op, v.a, v.b, lat, busy_cnt, to);
    check({tag, " timeout"}, 32'(to), 32'd0);
    check({tag, " result"}, 32'(result), 32'(v.res));
    check({tag, " rest"}, 32'(rest), 32'(v.rst));
    check({tag, " cout"}, 32'(cout), 32'(v.cout));
    check({tag, " div_zero"}, 32'(div_zero), 32'(v.dz));
    check({tag, " zero"}, 32'(zero), 32'(v.res == 8'h00));
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    int   e;
    int   done_hi;

    tbl[0] = '{2'd0, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 0};
    tbl[1] = '{2'd1, 8'h00, 8'h77, 8'hFF, 8'h00, 1'b1, 1'b0, 0};
    tbl[2] = '{2'd1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    tbl[3] = '{2'd2, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 8};
    tbl[4] = '{2'd2, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    tbl[5] = '{2'd2, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b1, 0};
    tbl[6] = '{2'd3, 8'hA5, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    tbl[7] = '{2'd2, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 8};
    tbl[8] = '{2'd2, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; num1 = 8'h00; num2 = 8'h00;
    #3;
    check("reset result", 32'(result), 32'h00);
    check("reset rest", 32'(rest), 32'h00);
    check("reset cout", 32'(cout), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      v = model(ro, ra, rb);
      apply_vec(v, $sformatf("rnd%0d op%0d %0h,%0h", i, ro, ra, rb));
    end

    // DIV 100/3 with operand changes and a second start while busy.
    @(negedge clk);
    op = 2'd2; num1 = 8'd100; num2 = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
    repeat (3) begin
      @(posedge clk);
      e++;
    end
    @(negedge clk);
    op = 2'd0; num1 = 8'hAA; num2 = 8'h05; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e++;
    while (done !== 1'b1 && e < 20) begin
      @(posedge clk);
      #1 e++;
    end
    check("ignore latency", 32'(e), 32'd8);
    check("ignore result", 32'(result), 32'h21);
    check("ignore rest", 32'(rest), 32'h01);
    done_hi = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done === 1'b1) done_hi++;
    end
    check("ignore no extra done", 32'(done_hi), 32'd0);
    check("ignore result held", 32'(result), 32'h21);

    // Reset during the 4th iteration of DIV 200/7.
    @(negedge clk);
    op = 2'd2; num1 = 8'd200; num2 = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst result", 32'(result), 32'h00);
    check("midrst rest", 32'(rest), 32'h00);
    check("midrst cout", 32'(cout), 32'd0);
    check("midrst div_zero", 32'(div_zero), 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_hi = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done === 1'b1) done_hi++;
    end
    check("midrst no done", 32'(done_hi), 32'd0);
    apply_vec(model(2'd0, 8'h6C, 8'h3A), "post-reset AND");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/and_dec_div8b_unit.md
# and_dec_div8b_unit

Sequenced 8-bit execution unit providing three ALU operations: bitwise AND, decrement-by-one and unsigned divide with remainder. It sits beside the combinational ALU datapath and takes the multi-cycle divide off the critical path. Operands are latched on a start strobe; results are registered and announced with a one-cycle `done` pulse.

## Interface
- No parameters; data width fixed at 8 bits.
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous reset, active low
- start  input  1  request strobe; sampled only while `busy`=0
- op  input  2  operation: 00 AND, 01 DEC, 10 DIV, 11 reserved
- num1  input  8  operand 1 (dividend for DIV, sole operand for DEC)
- num2  input  8  operand 2 (divisor for DIV; ignored by DEC)
- result  output  8  AND result / decremented value / quotient
- rest  output  8  DIV remainder; 0 for AND, DEC and reserved
- cout  output  1  DEC borrow (1 when num1 was 0x00); 0 otherwise
- div_zero  output  1  DIV attempted with num2 = 0; 0 otherwise
- zero  output  1  1 when the registered `result` is 0x00
- busy  output  1  divide iterations in progress
- done  output  1  one-cycle pulse: outputs updated for the last request

## Operation
- All arithmetic unsigned, modulo 2^8.
- AND: result = num1 & num2; rest = 0; cout = 0; div_zero = 0.
- DEC: result = num1 − 1 (0x00 wraps to 0xFF); cout = (num1 == 0x00); rest = 0; div_zero = 0.
- DIV, num2 ≠ 0: result = floor(num1/num2), rest = num1 mod num2. Restoring shift-subtract, one quotient bit per cycle, MSB first; internal 9-bit partial remainder; cout = 0; div_zero = 0.
- DIV, num2 = 0: result = 0xFF, rest = num1, div_zero = 1, cout = 0; no iterations.
- Reserved op 11: result = 0, rest = 0, all flags 0; `done` still pulses.
- `zero` always tracks the registered `result` (1 when `result` = 0x00).
- Operands and `op` are latched at the accepting edge; later input changes do not affect an in-flight divide.
- `start` while `busy`=1 is ignored (neither queued nor aborting).
- Outputs hold their values until the next completed request.
- States: IDLE; DIV_RUN with iteration count 0..7.
  - IDLE → DIV_RUN on start, op = DIV and num2 ≠ 0.
  - DIV_RUN → IDLE after the 8th iteration.

## Timing
- Reset (rst_n = 0, asynchronous): result = 0x00, rest = 0x00, cout = 0, div_zero = 0, zero = 1, busy = 0, done = 0, state IDLE.
- Reset mid-divide aborts the divide and discards it, with no `done` pulse.
- Edge E0 samples start = 1 while idle.
- AND, DEC, reserved op and divide-by-zero: outputs written at E0; `done` = 1 for the cycle after E0 (latency 1).
- DIV (num2 ≠ 0):
  - `busy` = 1 from after E0 until E8.
  - Iterations occur on edges E1..E8.
  - result and rest are written at E8; `done` = 1 for the cycle after E8 (latency 8 + 1).
  - `busy` = 0 in the same cycle `done` = 1; a new start may be accepted at that cycle's closing edge.
- `done` never stays high for two consecutive cycles unless back-to-back single-cycle ops are issued.

## Test plan
- Reset, then AND with num1 = 0xF0, num2 = 0x3C → result = 0x30, rest = 0, zero = 0, done 1 cycle after start.
- DEC with num1 = 0x00 → result = 0xFF, cout = 1. DEC with num1 = 0x01 → result = 0x00, zero = 1, cout = 0.
- DIV 200/7 → busy for 8 cycles, then result = 0x1C, rest = 0x04, done pulses once. Also DIV 0xFF/0x01 → result = 0xFF, rest = 0x00.
- DIV with num1 = 0x55, num2 = 0x00 → after 1 cycle: result = 0xFF, rest = 0x55, div_zero = 1, busy never asserted.
- Start DIV 100/3; change operands and pulse start during busy → result = 0x21, rest = 0x01, second start ignored.
- Start DIV; assert rst_n = 0 at iteration 4 → all outputs at reset values immediately, no done pulse; the next AND completes normally.
